// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - assembles a little-endian byte stream into instruction-memory writes
// Optional trailer checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_FIN   = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM  = 3'd5,
`endif
        S_DONE  = 3'd6
    } state_t;

    localparam logic [31:0]     DEPTH_W = 32'(DEPTH);
    localparam logic [ADDR_W:0] WL_MAX  = (ADDR_W + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [23:0]         shreg_q, shreg_d;
    logic [31:0]         n_q, n_d;
    logic [31:0]         rx_cnt_q, rx_cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_waddr_q, imem_waddr_d;
    logic [31:0]         imem_wdata_q, imem_wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W:0]     words_loaded_q, words_loaded_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]         csum_q, csum_d;
`endif

    logic        fire;
    logic        last_byte;
    logic [31:0] word;

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        shreg_d        = shreg_q;
        n_d            = n_q;
        rx_cnt_d       = rx_cnt_q;
        imem_we_d      = 1'b0;
        imem_waddr_d   = imem_waddr_q;
        imem_wdata_d   = imem_wdata_q;
        done_d         = done_q;
        err_d          = err_q;
        words_loaded_d = words_loaded_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d         = csum_q;
`endif
        fire      = in_valid && in_ready_q;
        last_byte = fire && (byte_cnt_q == 2'd3);
        // The 4th byte goes straight into the word; only bytes 0..2 are buffered.
        word      = {in_data, shreg_q};

        if (fire) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    shreg_d[7:0]   = in_data;
                2'd1:    shreg_d[15:8]  = in_data;
                2'd2:    shreg_d[23:16] = in_data;
                default: shreg_d        = shreg_q;
            endcase
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d        = S_HDR;
                    byte_cnt_d     = 2'd0;
                    rx_cnt_d       = 32'd0;
                    done_d         = 1'b0;
                    err_d          = 1'b0;
                    words_loaded_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d         = 32'd0;
`endif
                end
            end
            S_HDR: begin
                if (last_byte) begin
                    n_d        = word;
                    byte_cnt_d = 2'd0;
                    if (word > DEPTH_W) err_d = 1'b1;
                    state_d = (word == 32'd0) ? S_FIN : S_DATA;
                end
            end
            S_DATA: begin
                if (last_byte) begin
                    state_d  = S_WRITE;
                    rx_cnt_d = rx_cnt_q + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d   = csum_q + word;
`endif
                    // Overflow words are consumed but never written, so no wrap to word 0.
                    if (rx_cnt_q < DEPTH_W) begin
                        imem_we_d    = 1'b1;
                        imem_waddr_d = rx_cnt_q[ADDR_W-1:0];
                        imem_wdata_d = word;
                        if (words_loaded_q != WL_MAX)
                            words_loaded_d = words_loaded_q + (ADDR_W + 1)'(1);
                    end
                end
            end
            S_WRITE: begin
                byte_cnt_d = 2'd0;
                state_d    = (rx_cnt_q < n_q) ? S_DATA : S_FIN;
            end
            S_FIN: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d    = S_CSUM;
                byte_cnt_d = 2'd0;
`else
                state_d    = S_DONE;
                done_d     = 1'b1;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (last_byte) begin
                    if (word != csum_q) err_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_HDR) || (state_d == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                     || (state_d == S_CSUM)
`endif
                     ;
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            byte_cnt_q     <= 2'd0;
            shreg_q        <= 24'd0;
            n_q            <= 32'd0;
            rx_cnt_q       <= 32'd0;
            in_ready_q     <= 1'b0;
            imem_we_q      <= 1'b0;
            imem_waddr_q   <= '0;
            imem_wdata_q   <= 32'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            words_loaded_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q         <= 32'd0;
`endif
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            shreg_q        <= shreg_d;
            n_q            <= n_d;
            rx_cnt_q       <= rx_cnt_d;
            in_ready_q     <= in_ready_d;
            imem_we_q      <= imem_we_d;
            imem_waddr_q   <= imem_waddr_d;
            imem_wdata_q   <= imem_wdata_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
            words_loaded_q <= words_loaded_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_waddr   = imem_waddr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_hold     = busy_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_loaded_q;
endmodule
